fp_round_pack: RTL



---
 rtl/fp_round_pack.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fp_round_pack.sv
// Normalize (1 shift/cycle), round-nearest-even and pack an IEEE-754 single; out_valid 2+k cycles after accept (carry overflow: straight to DONE).
// in_ready only in IDLE, result held in DONE until out_ready; define FP_FTZ_EN to flush denormal results to signed zero.
module fp_round_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int GRD_W  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [EXP_W+FRAC_W+GRD_W+1:0]   in_data,
  input  logic                            in_carry,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_W+FRAC_W:0]           out_data,
  output logic                            out_ovf,
  output logic                            out_unf,
  output logic                            out_inexact
);

  localparam int SIG_W = FRAC_W + GRD_W + 1;
  localparam int MAN_W = FRAC_W + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_TOP = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t state, state_nxt;

  logic              sign;
  logic [EXP_W-1:0]  exp;
  logic [SIG_W-1:0]  sig;
  logic              sticky;

  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [SIG_W-1:0]  in_sig;
  logic              accept;
  logic              carry_ovf;
  logic              norm_stop;

  assign in_sign   = in_data[EXP_W+SIG_W];
  assign in_exp    = in_data[EXP_W+SIG_W-1:SIG_W];
  assign in_sig    = in_data[SIG_W-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready;
  assign carry_ovf = in_carry & (in_exp == EXP_TOP);
  assign norm_stop = (sig == '0) | sig[SIG_W-1] | (exp <= EXP_ONE);

  // Round-to-nearest-even on the guard bits.
  logic             g_bit, r_bit, s_bit, l_bit, rnd_up;
  logic [MAN_W:0]   rnd_sum;
  logic [EXP_W-1:0] res_exp;
  logic [FRAC_W-1:0] res_frac;
  logic             res_ovf, res_unf, res_inx;

  assign g_bit   = sig[GRD_W-1];
  assign r_bit   = sig[GRD_W-2];
  assign s_bit   = (|sig[GRD_W-3:0]) | sticky;
  assign l_bit   = sig[GRD_W];
  assign rnd_up  = g_bit & (r_bit | s_bit | l_bit);
  assign rnd_sum = {1'b0, sig[SIG_W-1:GRD_W]} + {{MAN_W{1'b0}}, rnd_up};

  always_comb begin
    res_exp  = '0;
    res_frac = '0;
    res_ovf  = 1'b0;
    res_inx  = g_bit | r_bit | s_bit;
    if (rnd_sum[MAN_W]) begin
      if (exp == EXP_TOP) begin
        res_exp = EXP_MAX;
        res_ovf = 1'b1;
      end else begin
        res_exp = exp + EXP_ONE;
      end
    end else if (rnd_sum[MAN_W-1]) begin
      // A denormal that rounds up into the hidden bit becomes the smallest normal.
      res_exp  = (exp == '0) ? EXP_ONE : exp;
      res_frac = rnd_sum[FRAC_W-1:0];
    end else begin
      res_frac = rnd_sum[FRAC_W-1:0];
    end
    res_unf = (res_exp == '0) & res_inx;
`ifdef FP_FTZ_EN
    if ((res_exp == '0) && (res_frac != '0)) begin
      res_frac = '0;
      res_unf  = 1'b1;
      res_inx  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = carry_ovf ? DONE : NORM;
      NORM:  if (norm_stop) state_nxt = ROUND;
      ROUND: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign        <= 1'b0;
      exp         <= '0;
      sig         <= '0;
      sticky      <= 1'b0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign <= in_sign;
            if (in_carry) begin
              sig    <= {1'b1, in_sig[SIG_W-1:1]};
              exp    <= in_exp + EXP_ONE;
              sticky <= in_sig[0];
            end else begin
              sig    <= in_sig;
              exp    <= in_exp;
              sticky <= 1'b0;
            end
            if (carry_ovf) begin
              out_data    <= {in_sign, EXP_MAX, {FRAC_W{1'b0}}};
              out_ovf     <= 1'b1;
              out_unf     <= 1'b0;
              out_inexact <= 1'b0;
            end
          end
        end
        NORM: begin
          if (!norm_stop) begin
            sig <= {sig[SIG_W-2:0], 1'b0};
            exp <= exp - EXP_ONE;
          end
        end
        ROUND: begin
          out_data    <= {sign, res_exp, res_frac};
          out_ovf     <= res_ovf;
          out_unf     <= res_unf;
          out_inexact <= res_inx;
        end
        default: ;
      endcase
    end
  end

endmodule
